// File: rtl/rgmii_tx_fmt.sv
// rgmii_tx_fmt: RGMII transmit formatter producing per-cycle DDR clock, data and control
// halves for 10/100/1000M, with speed changes applied only at clock-period boundaries.
module rgmii_tx_fmt #(
    parameter int DIV_10M = 50,
    parameter int DIV_100M = 5,
    localparam int CW = $clog2(DIV_10M > DIV_100M ? DIV_10M : DIV_100M)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] mac_gmii_txd,
    input  logic       mac_gmii_tx_en,
    input  logic       mac_gmii_tx_er,
    output logic       mac_gmii_tx_clk_en,
    output logic       tx_clk_1,
    output logic       tx_clk_2,
    output logic [3:0] txd_1,
    output logic [3:0] txd_2,
    output logic       tx_ctl_1,
    output logic       tx_ctl_2,
    output logic [1:0] active_speed,
    output logic       period_start
);
    localparam logic [CW:0] D10 = (CW+1)'(DIV_10M);
    localparam logic [CW:0] D100 = (CW+1)'(DIV_100M);
    logic [1:0] spd_n;
    logic [CW-1:0] ph, ph_n;
    logic [CW:0] d_cur, d_nxt, ph_x, ph_nx;
    logic [9:0] dat, sel;
    logic bnd, gig, cap, clk1_n, clk2_n;
    // Outputs are registered from the next-state values so pattern, phase and speed move together.
    always_comb begin
        d_cur = active_speed[0] ? D100 : D10;
        ph_x = {1'b0, ph};
        bnd = active_speed[1] || ph_x == d_cur - 1'b1;
        spd_n = bnd ? {speed[1], speed[0] & ~speed[1]} : active_speed;
        ph_n = bnd ? '0 : ph + 1'b1;
        ph_nx = {1'b0, ph_n};
        d_nxt = spd_n[0] ? D100 : D10;
        gig = spd_n[1];
        cap = gig || (!active_speed[1] && ph_x == (d_cur >> 1) - 1'b1);
        sel = cap ? {mac_gmii_txd, mac_gmii_tx_en, mac_gmii_tx_er} : dat;
        clk1_n = gig || {ph_n, 1'b0} < d_nxt;
        clk2_n = !gig && {ph_n, 1'b1} < d_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_speed <= 2'b10;
            ph <= '0;
            dat <= '0;
            tx_clk_1 <= 1'b1;
            tx_clk_2 <= 1'b0;
            txd_1 <= '0;
            txd_2 <= '0;
            tx_ctl_1 <= 1'b0;
            tx_ctl_2 <= 1'b0;
            mac_gmii_tx_clk_en <= 1'b0;
            period_start <= 1'b0;
        end else begin
            active_speed <= spd_n;
            ph <= ph_n;
            dat <= sel;
            tx_clk_1 <= clk1_n;
            tx_clk_2 <= clk2_n;
            txd_1 <= sel[5:2];
            txd_2 <= gig ? sel[9:6] : sel[5:2];
            tx_ctl_1 <= clk1_n ? sel[1] : sel[1] ^ sel[0];
            tx_ctl_2 <= clk2_n ? sel[1] : sel[1] ^ sel[0];
            mac_gmii_tx_clk_en <= gig || ph_nx == (d_nxt >> 1) - 1'b1;
            period_start <= ph_n == '0;
        end
    end
endmodule
